// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RISC-V M-extension multiply/divide unit: operation
// encoding (equal to funct3), FSM states and operand-signedness helpers.
package muldiv_unit_pkg;

  localparam int MD_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_mul_op(muldiv_op_e op);
    return !op[2];
  endfunction

  function automatic logic is_rem_op(muldiv_op_e op);
    return op[2] && op[1];
  endfunction

  // MUL is treated as signed x signed; its low half is sign-agnostic anyway.
  function automatic logic op1_signed(muldiv_op_e op);
    return (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
  endfunction

  function automatic logic op2_signed(muldiv_op_e op);
    return op1_signed(op) && (op != MD_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step.
// Exposes the next-step quotient/remainder so the caller can capture the final bit.
module div_core
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_i,
  input  logic                  step_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quotient_next_o,
  output logic [DATA_WIDTH-1:0] remainder_next_o
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0] quo_q, rem_q, dvs_q;
  logic [W:0]   shifted, diff;

  // A set top bit of diff means the trial subtraction borrowed: restore.
  assign shifted          = {rem_q, quo_q[W-1]};
  assign diff             = shifted - {1'b0, dvs_q};
  assign remainder_next_o = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  assign quotient_next_o  = {quo_q[W-2:0], ~diff[W]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (init_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quotient_next_o;
      rem_q <= remainder_next_o;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with IDLE/CALC/DONE control.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational MUL* ops.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  muldiv_op_e            op_i,
  input  logic [DATA_WIDTH-1:0] operand1_i,
  input  logic [DATA_WIDTH-1:0] operand2_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] dword_t;

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q;
  logic          sign_quo_q, sign_rem_q;
  logic [CW-1:0] cnt_q;
  word_t         result_q;

  logic  accept, last_step, is_mul, is_rem, div_zero, div_ovf, special, single_cycle;
  logic  neg1, neg2;
  word_t mag1, mag2, special_res, single_res, calc_res, div_res, q_next, r_next;

  function automatic word_t mul_select(dword_t prod, logic neg, muldiv_op_e op);
    dword_t p;
    p = neg ? -prod : prod;
    return (op == MD_MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  assign ready_o   = (state_q == ST_IDLE);
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE) && !flush_i;
  assign result_o  = result_q;
  assign accept    = valid_i && ready_o && !flush_i;
  assign last_step = (cnt_q == CW'(W - 1));

  // Accept-time decode: magnitudes, result signs and divide special cases.
  assign is_mul      = is_mul_op(op_i);
  assign is_rem      = is_rem_op(op_i);
  assign neg1        = op1_signed(op_i) && operand1_i[W-1];
  assign neg2        = op2_signed(op_i) && operand2_i[W-1];
  assign mag1        = neg1 ? -operand1_i : operand1_i;
  assign mag2        = neg2 ? -operand2_i : operand2_i;
  assign div_zero    = (operand2_i == '0);
  assign div_ovf     = ((op_i == MD_DIV) || (op_i == MD_REM)) &&
                       (operand1_i == {1'b1, {(W-1){1'b0}}}) && (operand2_i == '1);
  assign special     = !is_mul && (div_zero || div_ovf);
  assign special_res = div_zero ? (is_rem ? operand1_i : '1)
                                : (is_rem ? '0 : operand1_i);

  div_core #(.DATA_WIDTH(W)) u_div_core (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .init_i           (accept),
    .step_i           (state_q == ST_CALC),
    .dividend_i       (mag1),
    .divisor_i        (mag2),
    .quotient_next_o  (q_next),
    .remainder_next_o (r_next)
  );

  assign div_res = is_rem_op(op_q) ? (sign_rem_q ? -r_next : r_next)
                                   : (sign_quo_q ? -q_next : q_next);

`ifdef MULDIV_FAST_MUL_EN
  assign single_cycle = is_mul || special;
  assign single_res   = is_mul ? mul_select({{W{1'b0}}, mag1} * {{W{1'b0}}, mag2},
                                            neg1 ^ neg2, op_i)
                               : special_res;
  assign calc_res     = div_res;
`else
  dword_t     acc_q, acc_next;
  word_t      mcand_q;
  logic [W:0] mul_sum;

  // Shift-add: the low half starts as the multiplier and shifts out LSB-first.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign acc_next = {mul_sum, acc_q[W-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      mcand_q <= '0;
    end else if (accept) begin
      acc_q   <= {{W{1'b0}}, mag2};
      mcand_q <= mag1;
    end else if (state_q == ST_CALC) begin
      acc_q   <= acc_next;
    end
  end

  assign single_cycle = special;
  assign single_res   = special_res;
  assign calc_res     = is_mul_op(op_q) ? mul_select(acc_next, sign_quo_q, op_q) : div_res;
`endif

  // NOTE: state_d gets its default first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = single_cycle ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  // NOTE: datapath registers are reset too, so result_o is defined from reset on.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      op_q       <= MD_MUL;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q      <= '0;
        op_q       <= op_i;
        sign_quo_q <= neg1 ^ neg2;
        sign_rem_q <= neg1;
        if (single_cycle) result_q <= single_res;
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + 1'b1;
        if (last_step) result_q <= calc_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (DATA_WIDTH=32) plus hand-written
// flush, reset and operand-hold sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  muldiv_op_e  op = MD_MUL;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        ready, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .flush_i    (flush),
    .op_i       (op),
    .operand1_i (op1),
    .operand2_i (op2),
    .ready_o    (ready),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!ready && guard < 100) begin
      tick();
      guard++;
    end
    valid = 1'b1;
    op    = o;
    op1   = a;
    op2   = b;
    tick();
    valid = 1'b0;
    op1   = 32'hdead_beef;
    op2   = 32'h0bad_f00d;
  endtask

  // lat counts cycles from accept until done_o; 100 means it never came.
  task automatic wait_done(output logic [31:0] res, output int lat, output bit ready_seen);
    lat        = 1;
    ready_seen = 1'b0;
    while (!done && lat < 100) begin
      if (ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat, n;
    bit          rdy_seen;
    logic [31:0] last_res;

    vecs[0]  = '{MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat};
    vecs[1]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat};
    vecs[2]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat};
    vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MulLat};
    vecs[4]  = '{MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MulLat};
    vecs[5]  = '{MD_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, DivLat};
    vecs[6]  = '{MD_REM,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, DivLat};
    vecs[7]  = '{MD_DIVU,   32'd100,       32'd7,         32'd14,        DivLat};
    vecs[8]  = '{MD_REMU,   32'd100,       32'd7,         32'd2,         DivLat};
    vecs[9]  = '{MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DivLat};
    vecs[10] = '{MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{MD_REMU,   32'd5,         32'd0,         32'd5,         1};
    vecs[12] = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[13] = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};

    repeat (2) tick();
    check("reset ready",  {31'd0, ready}, 32'd1);
    check("reset busy",   {31'd0, busy},  32'd0);
    check("reset done",   {31'd0, done},  32'd0);
    check("reset result", result,         32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      accept_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(res, lat, rdy_seen);
      check($sformatf("vec%0d %s result", i, vecs[i].op.name()), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d ready while busy", i), {31'd0, rdy_seen}, 32'd0);
    end
    last_res = vecs[13].exp;

    // Flush ten cycles into a DIV: no done, idle next cycle, result untouched.
    tick();
    accept_op(MD_DIV, 32'd1000, 32'd3);
    count_done(9, n);
    flush = 1'b1;
    if (done) n++;
    tick();
    flush = 1'b0;
    check("flush no done",   n, 0);
    check("flush ready",     {31'd0, ready}, 32'd1);
    check("flush busy",      {31'd0, busy},  32'd0);
    check("flush result",    result, last_res);
    accept_op(MD_DIVU, 32'd9, 32'd2);
    wait_done(res, lat, rdy_seen);
    check("post-flush DIVU result",  res, 32'd4);
    check("post-flush DIVU latency", lat, DivLat);
    tick();

    // flush_i together with valid_i in IDLE must not accept.
    valid = 1'b1;
    flush = 1'b1;
    op    = MD_DIVU;
    op1   = 32'd8;
    op2   = 32'd2;
    tick();
    valid = 1'b0;
    flush = 1'b0;
    check("flush+valid busy",  {31'd0, busy},  32'd0);
    check("flush+valid ready", {31'd0, ready}, 32'd1);
    count_done(40, n);
    check("flush+valid no done", n, 0);

    // Reset in the middle of a DIV.
    accept_op(MD_DIV, 32'd50, 32'd5);
    count_done(5, n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-rst ready",  {31'd0, ready}, 32'd1);
    check("mid-rst busy",   {31'd0, busy},  32'd0);
    check("mid-rst done",   {31'd0, done},  32'd0);
    check("mid-rst result", result,         32'd0);
    count_done(40, n);
    check("mid-rst no done", n, 0);

    // valid_i held with changing operands: only the first request is served.
    valid = 1'b1;
    op    = MD_DIVU;
    op1   = 32'd100;
    op2   = 32'd7;
    tick();
    lat = 1;
    while (!done && lat < 100) begin
      op  = MD_REM;
      op1 = $urandom;
      op2 = $urandom | 32'd1;
      tick();
      lat++;
    end
    valid = 1'b0;
    check("held-valid result",  result, 32'd14);
    check("held-valid latency", lat,    DivLat);
    tick();
    check("held-valid no re-accept", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
